// File: rtl/an_residue_mod_serial.sv
// Serial CW mod A residue engine for the AN-code SEC decoder: MSB-first Horner reduction, CHUNK bits per cycle.
// Optional build macro AN_RES_ERRCNT_EN adds a saturating 16-bit count of nonzero residues handed downstream.
module an_residue_mod_serial #(
    parameter int CW_W  = 66,
    parameter int CHUNK = 8,
    parameter int A     = 131,
    parameter int R_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] cw_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [R_W-1:0]  r_out,
    output logic [CW_W-1:0] cw_out
`ifdef AN_RES_ERRCNT_EN
    ,
    output logic [15:0]     err_cnt
`endif
);

    localparam int NCH   = (CW_W + CHUNK - 1) / CHUNK;
    localparam int SW    = NCH * CHUNK;
    localparam int CNT_W = $clog2(NCH + 1);
    localparam logic [R_W:0] A_EXT = (R_W + 1)'(A);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [SW-1:0]    sh_reg;
    logic [R_W-1:0]   acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [R_W-1:0]   acc_next;
    logic             last_chunk;

    // Bit-serial Horner unrolled CHUNK times: each stage doubles, adds one bit and
    // does a single conditional subtract. Since the input stage is < A, 2*x+b < 2A,
    // so one subtract keeps every stage < A and the result is exact mod A.
    logic [R_W-1:0] stage [0:CHUNK];
    assign stage[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_red
            logic [R_W:0] dbl;
            assign dbl = {stage[gi], sh_reg[SW-1-gi]};
            assign stage[gi+1] = R_W'((dbl >= A_EXT) ? dbl - A_EXT : dbl);
        end
    endgenerate

    assign acc_next   = stage[CHUNK];
    assign last_chunk = (cnt_reg == CNT_W'(NCH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_reg  <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
            r_out   <= '0;
            cw_out  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sh_reg  <= SW'(cw_in);
                        cw_out  <= cw_in;
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    sh_reg  <= sh_reg << CHUNK;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_chunk) r_out <= acc_next;
                end
                default: ;
            endcase
        end
    end

`ifdef AN_RES_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && (r_out != '0) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_an_residue_mod_serial.sv
// Scoreboard bench for an_residue_mod_serial: directed residues, latency, backpressure, mid-CALC reset, random words.
module tb_an_residue_mod_serial;

    localparam int CW_W = 66;
    localparam int R_W  = 8;
    localparam int NCH  = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW_W-1:0] cw_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [R_W-1:0]  r_out;
    logic [CW_W-1:0] cw_out;
`ifdef AN_RES_ERRCNT_EN
    logic [15:0]     err_cnt;
    int              err_model = 0;
`endif

    an_residue_mod_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cw_in     (cw_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .cw_out    (cw_out)
`ifdef AN_RES_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW_W-1:0] cw;
        logic [R_W-1:0]  r;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [R_W-1:0] ref_mod(input logic [CW_W-1:0] w);
        logic [127:0] x;
        x = 128'(w);
        return R_W'(x % 128'd131);
    endfunction

    // Expected result is pushed at the moment the word is offered.
    task automatic send(input logic [CW_W-1:0] w, input logic [R_W-1:0] r_exp);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        cw_in    = w;
        sb_q.push_back('{cw: w, r: r_exp});
        $display("send cw=%0h exp_r=%0d", w, r_exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk(tag, 128'(sb_q.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out", 128'(cw_out), 128'(~cw_out));
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                $display("recv cw=%0h r=%0d exp_r=%0d", cw_out, r_out, e.r);
                chk("r_out", 128'(r_out), 128'(e.r));
                chk("cw_out", 128'(cw_out), 128'(e.cw));
`ifdef AN_RES_ERRCNT_EN
                if (e.r != '0 && err_model < 16'hFFFF) err_model++;
`endif
            end
        end
    end

    initial begin
        logic [CW_W-1:0] w;
        logic [R_W-1:0]  hr;
        logic [CW_W-1:0] hcw;
        int lat;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_r_out", 128'(r_out), 128'd0);
        chk("rst_cw_out", 128'(cw_out), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiple of A, with latency measured from the handshake cycle
        send(CW_W'(131 * 12345), 8'd0);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 128'(lat), 128'(NCH + 1));
        drain("drain_t1");

        // Directed residues, back to back
        send(CW_W'(1) << 64, 8'd65);
        send((CW_W'(1) << 40) + CW_W'(131 * 5), 8'd84);
        send(CW_W'(131 * 1000 + 1), 8'd1);
        send({CW_W{1'b1}}, 8'd128);
        send('0, 8'd0);
        drain("drain_t2");

        // Backpressure: hold DONE, offer a word that must be ignored
        out_ready = 1'b0;
        w = CW_W'(66'h2_DEAD_BEEF_1234_5678);
        send(w, ref_mod(w));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_reach_done", 128'(out_valid), 128'd1);
        hr  = r_out;
        hcw = cw_out;
        chk("bp_r_value", 128'(hr), 128'(ref_mod(w)));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            cw_in    = CW_W'(66'h1_1111_2222_3333_4444);
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_r_stable", 128'(r_out), 128'(hr));
            chk("bp_cw_stable", 128'(cw_out), 128'(hcw));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_back_idle", 128'(in_ready), 128'd1);
        chk("bp_valid_low", 128'(out_valid), 128'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("bp_no_capture", 128'(out_valid), 128'd0);

        // Reset during CALC cycle 4 discards the word
        w = CW_W'(66'h3_0F0F_0F0F_0F0F_0F0F);
        send(w, ref_mod(w));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
`ifdef AN_RES_ERRCNT_EN
        err_model = 0;
        chk("abort_err_cnt", 128'(err_cnt), 128'd0);
`endif
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_r_out", 128'(r_out), 128'd0);
        chk("abort_cw_out", 128'(cw_out), 128'd0);
        w = CW_W'(66'h1_2345_6789_ABCD_EF01);
        send(w, ref_mod(w));
        drain("drain_t5");

        // Random words, including an occasional all-zero top chunk
        for (int i = 0; i < 20; i++) begin
            w = CW_W'({$urandom, $urandom, $urandom});
            if (i % 5 == 0) w[CW_W-1:CW_W-10] = '0;
            send(w, ref_mod(w));
        end
        drain("drain_rand");

`ifdef AN_RES_ERRCNT_EN
        @(posedge clk); #1;
        chk("err_cnt", 128'(err_cnt), 128'(err_model));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
